// File: rtl/bcd_scan7.sv
// bcd_scan7: multiplexed 7-seg driver for DIGITS packed BCD digits.
// Ports: clk, rst (sync, active-low), bcd, load -> seg, an, frame_tick.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_scan7 #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pcnt, pcnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [4*DIGITS-1:0]   frame, frame_n;
  logic [4*DIGITS-1:0]   pend, pend_n;
  logic                  pend_v, pend_v_n;
  logic                  last_p, bnd;
  logic [3:0]            dig;
  logic [6:0]            seg_n;
  logic [DIGITS-1:0]     an_n;
  logic [DIGITS-1:0]     hizero;
  logic                  nz;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  always_comb begin
    last_p   = (pcnt == PW'(PRESCALE - 1));
    bnd      = last_p && (idx == IW'(DIGITS - 1));
    pcnt_n   = last_p ? '0 : pcnt + 1'b1;
    idx_n    = idx;
    frame_n  = frame;
    pend_n   = pend;
    pend_v_n = pend_v;
    if (last_p)
      idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    if (bnd) begin
      // A load landing on the boundary itself bypasses pend.
      if (load)
        frame_n = bcd;
      else if (pend_v)
        frame_n = pend;
      pend_v_n = 1'b0;
    end else if (load) begin
      pend_n   = bcd;
      pend_v_n = 1'b1;
    end
  end

  // hizero[i]: digits i..DIGITS-1 of the next frame are all zero.
  always_comb begin
    nz     = 1'b0;
    hizero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz        = nz | (|frame_n[4*i +: 4]);
      hizero[i] = !nz;
    end
  end

  always_comb begin
    dig   = frame_n[4*idx_n +: 4];
    seg_n = dec(dig);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_n != '0) && hizero[idx_n])
      seg_n = 7'h00;
`endif
    an_n = '0;
    for (int i = 0; i < DIGITS; i++)
      an_n[i] = (idx_n == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt       <= '0;
      idx        <= '0;
      frame      <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      seg        <= 7'h00;
      an         <= '0;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      idx        <= idx_n;
      frame      <= frame_n;
      pend       <= pend_n;
      pend_v     <= pend_v_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_tick <= bnd;
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  logic unused;
  assign unused = ^hizero;
`endif

endmodule

// File: tb/tb_bcd_scan7.sv
// tb_bcd_scan7: directed plus random checks of bcd_scan7
// against a cycle-count based reference model.
module tb_bcd_scan7;

  localparam int D  = 4;
  localparam int P  = 2;
  localparam int FL = D * P;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   bcd = '0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic [D-1:0]  an;
  logic          frame_tick;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  logic [15:0] m_frame = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;
  logic        m_out = 1'b0;
  logic        m_tick = 1'b0;

  bcd_scan7 #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .load(load),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [15:0] f, input int i);
    logic [6:0] tbl [10];
    int d;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    d = int'((f >> (4 * i)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (f >> (4 * i)) == 16'h0)
      return 7'h00;
`endif
    return (d < 10) ? tbl[d] : 7'h40;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] b);
    logic bnd;
    int di;
    rst  = r;
    load = l;
    bcd  = b;
    @(posedge clk);
    bnd = r && (cyc % FL == FL - 1);
    if (!r) begin
      cyc = 0; m_frame = '0; m_pend = '0; m_pv = 0;
      m_out = 0; m_tick = 0;
    end else begin
      if (bnd) begin
        if (l) m_frame = b;
        else if (m_pv) m_frame = m_pend;
        m_pv = 0;
      end else if (l) begin
        m_pend = b;
        m_pv = 1;
      end
      cyc = (cyc + 1) % FL;
      m_out = 1;
      m_tick = bnd;
    end
    #1;
    di = (cyc / P) % D;
    chk("an", 32'(an), m_out ? 32'(1 << di) : 32'd0);
    chk("seg", 32'(seg), m_out ? 32'(ref_seg(m_frame, di)) : 32'd0);
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, bcd);
  endtask

  task automatic to_boundary();
    while (cyc % FL != FL - 1) step(1'b1, 1'b0, bcd);
  endtask

  initial begin
    #2;
    // reset held for 3 edges, then one full frame
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0);
    idle(FL + 2);
    // single load shown after boundary
    step(1'b1, 1'b1, 16'h1234);
    idle(2 * FL);
    // last load wins
    to_boundary();
    idle(1);
    step(1'b1, 1'b1, 16'h1111);
    idle(1);
    step(1'b1, 1'b1, 16'h5678);
    idle(2 * FL);
    // load exactly on the boundary cycle
    to_boundary();
    step(1'b1, 1'b1, 16'h0009);
    idle(FL);
    // invalid codes show as dash
    step(1'b1, 1'b1, 16'hF0A0);
    idle(2 * FL);
    // reset mid-frame discards a pending load
    idle(1);
    step(1'b1, 1'b1, 16'h4321);
    step(1'b0, 1'b0, 16'h0);
    idle(2 * FL);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic r, l;
      logic [15:0] b;
      r = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 5) == 0);
      b = 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        b = b & 16'h00FF;
      step(r, l, b);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
